// File: rtl/sram_req_arbiter_pkg.sv
// Shared master ids, SRAM-like size encodings and the request payload bundle
// used by the inst/data arbiter.
package sram_req_arbiter_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// Small id FIFO recording which master issued each accepted request, so that
// in-order responses can be routed back.
module arb_id_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural overflow
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst and data masters: data-first grant with
// a starvation escape for inst, request lock, and in-order response routing.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        down_req,
  output logic        down_wr,
  output logic [1:0]  down_size,
  output logic [31:0] down_addr,
  output logic [3:0]  down_wstrb,
  output logic [31:0] down_wdata,
  input  logic        down_addr_ok,
  input  logic        down_data_ok,
  input  logic [31:0] down_rdata,
  output logic        err_spurious
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(OUTSTANDING + 1);

  sram_req_t       inst_pl, data_pl, sel_pl;
  logic            grant, sel_req, hs, pop;
  logic            lock, lock_id;
  logic            full, empty, head_id;
  logic [SW-1:0]   starve_cnt;
  logic [CW-1:0]   count;

  assign inst_pl = '{wr: inst_wr, size: inst_size, addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};

  always_comb begin
    grant = MST_INST;
    if (lock)
      grant = lock_id;
    else if (inst_req && data_req)
      grant = (starve_cnt == SW'(STARVE_LIMIT)) ? MST_INST : MST_DATA;
    else if (data_req)
      grant = MST_DATA;
  end

  assign sel_req = (grant == MST_DATA) ? data_req : inst_req;
  assign sel_pl  = (grant == MST_DATA) ? data_pl : inst_pl;

  // Full blocks the request even when a pop lands in the same cycle
  assign down_req   = sel_req & ~full;
  assign down_wr    = sel_pl.wr;
  assign down_size  = sel_pl.size;
  assign down_addr  = sel_pl.addr;
  assign down_wstrb = sel_pl.wstrb;
  assign down_wdata = sel_pl.wdata;

  assign hs           = down_req & down_addr_ok;
  assign inst_addr_ok = hs & (grant == MST_INST);
  assign data_addr_ok = hs & (grant == MST_DATA);

  assign pop          = down_data_ok & ~empty;
  assign inst_data_ok = pop & (head_id == MST_INST);
  assign data_data_ok = pop & (head_id == MST_DATA);
  assign inst_rdata   = down_rdata;
  assign data_rdata   = down_rdata;

  arb_id_fifo #(.WIDTH(1), .DEPTH(OUTSTANDING)) u_id_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (hs),
    .pop     (pop),
    .din     (grant),
    .dout    (head_id),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock         <= 1'b0;
      lock_id      <= MST_INST;
      starve_cnt   <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (hs) begin
        lock <= 1'b0;
        if (grant == MST_INST)
          starve_cnt <= '0;
        else if (inst_req && starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + SW'(1);
      end else if (down_req) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (down_data_ok && empty) err_spurious <= 1'b1;
    end
  end

  a_full_count : assert property (@(posedge aclk) disable iff (!aresetn)
    full == (count == CW'(OUTSTANDING)));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboarded bench for sram_req_arbiter: directed scenarios plus random
// traffic checked against a queue-based reference of the arbitration rules.
module tb_sram_req_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        down_req, down_wr;
  logic [1:0]  down_size;
  logic [31:0] down_addr, down_wdata, down_rdata;
  logic [3:0]  down_wstrb;
  logic        down_addr_ok, down_data_ok, err_spurious;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  sram_req_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .down_req(down_req), .down_wr(down_wr), .down_size(down_size), .down_addr(down_addr),
    .down_wstrb(down_wstrb), .down_wdata(down_wdata), .down_addr_ok(down_addr_ok),
    .down_data_ok(down_data_ok), .down_rdata(down_rdata), .err_spurious(err_spurious)
  );

  function automatic logic [31:0] rfun(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: id queue of outstanding requests plus grant rules
  typedef struct { bit id; logic [31:0] rd; } ent_t;
  ent_t        m_q[$];
  logic [31:0] exp_i[$], exp_d[$];
  logic [31:0] b_q[$];
  bit          dut_glog[$];
  bit          m_lock, m_lock_id, m_err;
  int          m_starve;

  always @(negedge aclk) begin
    bit g, ir, dr, rq, ereq, ehs, epop;
    logic [70:0] pl_i, pl_d;
    if (!aresetn) begin
      m_q.delete(); exp_i.delete(); exp_d.delete();
      m_lock = 0; m_lock_id = 0; m_err = 0; m_starve = 0;
    end else begin
      ir = inst_req; dr = data_req;
      pl_i = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
      pl_d = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
      if (m_lock) g = m_lock_id;
      else if (ir && dr) g = (m_starve == 8) ? 1'b0 : 1'b1;
      else g = dr;
      rq   = g ? dr : ir;
      ereq = rq && (m_q.size() < 4);
      ehs  = ereq && down_addr_ok;
      epop = down_data_ok && (m_q.size() > 0);
      chk("down_req", down_req, ereq);
      if (ereq) chk("down_payload", {down_wr, down_size, down_addr, down_wstrb, down_wdata}, g ? pl_d : pl_i);
      chk("inst_addr_ok", inst_addr_ok, ehs && !g);
      chk("data_addr_ok", data_addr_ok, ehs && g);
      chk("inst_data_ok", inst_data_ok, epop && m_q[0].id == 1'b0);
      chk("data_data_ok", data_data_ok, epop && m_q[0].id == 1'b1);
      chk("err_spurious", err_spurious, m_err);
      if (down_data_ok && m_q.size() == 0) m_err = 1;
      if (epop) void'(m_q.pop_front());
      if (ehs) begin
        m_q.push_back('{g, rfun(g ? data_addr : inst_addr)});
        if (g) exp_d.push_back(rfun(data_addr));
        else   exp_i.push_back(rfun(inst_addr));
        m_lock = 0;
        if (!g) m_starve = 0;
        else if (ir && m_starve < 8) m_starve++;
      end else if (ereq) begin
        m_lock = 1; m_lock_id = g;
      end
    end
  end

  // Bridge: answers in order with data derived from the address it accepted
  always @(negedge aclk) begin
    if (!aresetn) begin
      b_q.delete(); dut_glog.delete();
    end else begin
      if (down_data_ok && b_q.size() > 0) void'(b_q.pop_front());
      if (down_req && down_addr_ok) begin
        b_q.push_back(rfun(down_addr));
        dut_glog.push_back(data_addr_ok);
      end
    end
  end

  always @(posedge aclk) begin
    #2;
    down_rdata = (b_q.size() > 0) ? b_q[0] : 32'hdead_beef;
  end

  // Response monitor
  always @(negedge aclk) begin
    if (aresetn) begin
      if (inst_data_ok) begin
        chk("inst_resp_pending", exp_i.size() > 0, 1);
        if (exp_i.size() > 0) chk("inst_rdata", inst_rdata, exp_i.pop_front());
      end
      if (data_data_ok) begin
        chk("data_resp_pending", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) chk("data_rdata", data_rdata, exp_d.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wstrb = 4'hf; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wstrb = 4'hf; data_wdata = 0;
    down_addr_ok = 0; down_data_ok = 0;
  endtask

  task automatic do_reset();
    cyc();
    idle();
    aresetn = 0;
    #1;
    chk("rst_outputs", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, down_req, err_spurious}, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
  endtask

  task automatic step_rand(int pi, int pd, int pa, int pk);
    bit i_acc, d_acc;
    @(negedge aclk);
    i_acc = inst_addr_ok; d_acc = data_addr_ok;
    cyc();
    if (inst_req && i_acc) inst_req = 0;
    if (data_req && d_acc) data_req = 0;
    if (!inst_req && ($urandom % 100) < pi) begin
      inst_req = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
      inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
    end
    if (!data_req && ($urandom % 100) < pd) begin
      data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
      data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
    end
    down_addr_ok = ($urandom % 100) < pa;
    down_data_ok = (b_q.size() > 0) && (($urandom % 100) < pk);
  endtask

  task automatic drain();
    int n = 0;
    while ((inst_req || data_req || b_q.size() > 0) && n < 300) begin
      step_rand(0, 0, 100, 100);
      n++;
    end
    chk("drain_in_budget", n < 300, 1);
    down_addr_ok = 0; down_data_ok = 0;
    @(negedge aclk);
    chk("inst_resp_all_seen", exp_i.size(), 0);
    chk("data_resp_all_seen", exp_d.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    idle();
    aresetn = 0;

    // Single inst read, response three cycles after accept
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0000; down_addr_ok = 1;
    @(negedge aclk);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0; down_addr_ok = 0;
    cyc();
    cyc(); down_data_ok = 1;
    @(negedge aclk);
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, rfun(32'h1c00_0000));
    chk("t1_data_data_ok", data_data_ok, 0);
    cyc(); down_data_ok = 0;

    // Both request: data first, then inst; responses D then I
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h8000_2000; down_addr_ok = 1;
    @(negedge aclk);
    chk("t2_data_first", data_addr_ok, 1);
    chk("t2_inst_waits", inst_addr_ok, 0);
    cyc(); data_req = 0;
    @(negedge aclk);
    chk("t2_inst_next", inst_addr_ok, 1);
    cyc(); inst_req = 0; down_addr_ok = 0; down_data_ok = 1;
    @(negedge aclk);
    chk("t2_resp_d", data_data_ok, 1);
    chk("t2_resp_d_rdata", data_rdata, rfun(32'h8000_2000));
    cyc();
    @(negedge aclk);
    chk("t2_resp_i", inst_data_ok, 1);
    chk("t2_resp_i_rdata", inst_rdata, rfun(32'h0000_1000));
    cyc(); down_data_ok = 0;

    // Lock holds inst while the bridge stalls, even after data arrives
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_0a00;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h0000_0d00; end
      @(negedge aclk);
      chk("t3_locked_addr", down_addr, 32'h0000_0a00);
      chk("t3_no_accept", inst_addr_ok | data_addr_ok, 0);
      cyc();
    end
    down_addr_ok = 1;
    @(negedge aclk);
    chk("t3_inst_accept", inst_addr_ok, 1);
    cyc(); inst_req = 0;
    @(negedge aclk);
    chk("t3_data_after", data_addr_ok, 1);
    chk("t3_data_addr", down_addr, 32'h0000_0d00);
    cyc(); data_req = 0; down_addr_ok = 0; down_data_ok = 1;
    cyc(); cyc(); down_data_ok = 0;

    // Continuous contention: 8 data grants then 1 inst grant
    do_reset();
    n = 0;
    while (dut_glog.size() < 27 && n < 100) begin
      step_rand(100, 100, 100, 100);
      n++;
    end
    chk("t4_grants_in_budget", n < 100, 1);
    for (int i = 0; i < 27 && i < dut_glog.size(); i++)
      chk($sformatf("t4_grant_%0d", i), dut_glog[i], (i % 9 == 8) ? 0 : 1);
    drain();

    // Outstanding limit: 4 accepted, 5th blocked even on the freeing cycle
    do_reset();
    down_addr_ok = 1; data_req = 1; data_addr = 32'h0000_4000;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("t5_accept", data_addr_ok, 1);
      cyc(); data_addr = 32'h0000_4000 + 32'(4 * (k + 1));
    end
    @(negedge aclk);
    chk("t5_full_blocks", down_req, 0);
    cyc(); down_data_ok = 1;
    @(negedge aclk);
    chk("t5_pop_resp", data_data_ok, 1);
    chk("t5_no_same_cycle", down_req, 0);
    cyc(); down_data_ok = 0;
    @(negedge aclk);
    chk("t5_fifth_accept", data_addr_ok, 1);
    cyc(); data_req = 0; down_addr_ok = 0; down_data_ok = 1;
    repeat (4) cyc();
    down_data_ok = 0;

    // Random traffic against the reference
    do_reset();
    repeat (3000) step_rand(40, 60, 60, 40);
    drain();

    // Spurious response and asynchronous reset mid-burst
    do_reset();
    down_data_ok = 1;
    @(negedge aclk);
    chk("t6_no_data_ok", inst_data_ok | data_data_ok, 0);
    cyc(); down_data_ok = 0;
    @(negedge aclk);
    chk("t6_err_set", err_spurious, 1);
    cyc(); cyc();
    @(negedge aclk);
    chk("t6_err_sticky", err_spurious, 1);
    cyc(); down_addr_ok = 1; data_req = 1; data_addr = 32'h0000_7000;
    cyc(); cyc();
    #2;
    aresetn = 0; data_req = 0; down_addr_ok = 0;
    #1;
    chk("t6_async_clear", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, down_req, err_spurious}, 0);
    @(posedge aclk); #1 aresetn = 1;
    down_data_ok = 1;
    @(negedge aclk);
    chk("t6_fifo_cleared", inst_data_ok | data_data_ok, 0);
    cyc(); down_data_ok = 0;
    @(negedge aclk);
    chk("t6_err_after_reset", err_spurious, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
